serdes_tx_scheduler: RTL
========================

// Module: serdes_tx_scheduler
// PURPOSE
//  Arbitrates two parallel-word requesters onto one serial TX line and sequences the frame serializer.
//  The requesters are the switch-capture port and the pattern generator. Arbitration is round-robin.
//  Frame: start(0), DATA_W data bits LSB-first, even parity, stop(1). Line idles high.
//  Sits between the DE1 front end (SW/KEY capture) and the serial output pin/LED.
// PARAMETERS
//  DATA_W      8   data bits per frame (>=1)
//  BIT_CYCLES  4   clocks each serial bit is held (>=1; 1 legal)
// PORTS
//  CLOCK_50     in   1       system clock, all logic on rising edge
//  reset        in   1       synchronous, active-high reset
//  req0_valid   in   1       requester 0 has a word
//  req0_data    in   DATA_W  requester 0 word
//  req0_ready   out  1       requester 0 word accepted this cycle
//  req1_valid   in   1       requester 1 has a word
//  req1_data    in   DATA_W  requester 1 word
//  req1_ready   out  1       requester 1 word accepted this cycle
//  serial_out   out  1       registered serial line
//  busy         out  1       high whenever state != IDLE
//  grant_id     out  1       requester owning the current/last frame
//  frame_done   out  1       1-cycle pulse on the final cycle of STOP
// BEHAVIOUR
//  Reset values:
//   - serial_out=1, busy=0, grant_id=0, frame_done=0, state=IDLE.
//   - last_grant=1, so req0 wins the first tie.
//   - req*_ready=0 while reset is high.
//  States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
//   - Each non-IDLE state holds its bit for BIT_CYCLES clocks.
//   - DATA repeats for DATA_W bits using a bit index 0..DATA_W-1.
//   - Bit timer: counter 0..BIT_CYCLES-1; the state/bit advances when the counter reaches BIT_CYCLES-1.
//  Arbitration, in IDLE only:
//   - Only one valid -> that requester wins.
//   - Both valid -> the requester != last_grant wins.
//   - The winner's ready is combinationally high in that IDLE cycle; the loser's ready is low.
//   - All readies are 0 outside IDLE.
//  Transfer (valid & ready at a clock edge):
//   - Captures the data word, sets grant_id and last_grant, moves to START.
//   - Computes parity = ^data.
//   - Requester data/valid may change after acceptance with no effect on the frame.
//  Latency:
//   - serial_out=0 (start bit) from the edge after acceptance.
//   - Frame occupies (DATA_W+3)*BIT_CYCLES cycles.
//  Frame completion:
//   - frame_done is high during the last STOP cycle, then state returns to IDLE.
//   - IDLE lasts >=1 cycle with serial_out=1. Back-to-back frames therefore repeat every (DATA_W+3)*BIT_CYCLES+1 cycles.
//  No valid in IDLE: stays IDLE with serial_out=1 and busy=0.
//  valid deasserted without ready: no transfer, no state change; no requirement on requester.
//  Reset mid-frame:
//   - Frame is aborted and the captured word discarded.
//   - Next edge gives serial_out=1 and IDLE.
//   - last_grant returns to 1.
//  Simultaneous frame_done and new valid: the new request is not accepted until the following IDLE cycle.
// TESTING
//  - BIT_CYCLES=4, req0 sends 8'hA9:
//    - line sequence per 4 clocks is 0,1,0,0,1,0,1,0,1,0,1;
//    - frame is 44 cycles;
//    - frame_done pulses once; grant_id=0.
//  - Both valid from reset with data 8'h01/8'h80, held:
//    - grants go 0,1,0,1;
//    - parity bits are 1 and 1;
//    - frame period is 45 cycles.
//  - req1 alone sends 8'hFF:
//    - parity=0, grant_id=1;
//    - req0_ready stays 0 throughout.
//  - Reset pulsed 1 cycle at cycle 20 of a frame:
//    - serial_out=1 and busy=0 on the next edge;
//    - no frame_done;
//    - next tie goes to req0.
//  - BIT_CYCLES=1, req0 held with 8'h00:
//    - 11-cycle frames, period 12;
//    - parity 0, stop 1;
//    - exactly one ready pulse per frame.
//  - Idle, no valid for 100 cycles: serial_out=1, busy=0, and all readies 0 (no valid, so no grant).

Source files
------------

// File: rtl/serdes_tx_scheduler.sv
// serdes_tx_scheduler: round-robin arbiter for two parallel-word requesters
// feeding a single UART-style serial frame generator.
// Frame: start(0), DATA_W data bits LSB-first, even parity, stop(1); idle high.
module serdes_tx_scheduler #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              serial_out,
  output logic              busy,
  output logic              grant_id,
  output logic              frame_done
);

  localparam int TMR_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              serial_q, serial_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              in_idle, win0, win1, bit_end;

  // The current serial bit has been held for its full BIT_CYCLES clocks
  assign bit_end    = (timer_q == TMR_LAST);
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_STOP) && bit_end;
  assign serial_out = serial_q;
  assign grant_id   = grant_q;

  // Round-robin arbitration; grants are only offered in IDLE and outside reset
  always_comb begin
    in_idle    = (state_q == S_IDLE) && !reset;
    win0       = req0_valid && (!req1_valid || last_grant_q);
    win1       = req1_valid && (!req0_valid || !last_grant_q);
    req0_ready = in_idle && win0;
    req1_ready = in_idle && win1;
  end

  // Frame sequencer next-state, plus the line level for the state being entered
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    serial_d     = 1'b1;

    if (state_q != S_IDLE) begin
      timer_d = bit_end ? '0 : timer_q + TMR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (req0_ready || req1_ready) begin
          // The word is captured here so the requester is free to move on
          shift_d      = req1_ready ? req1_data : req0_data;
          parity_d     = req1_ready ? ^req1_data : ^req0_data;
          grant_d      = req1_ready;
          last_grant_d = req1_ready;
          timer_d      = '0;
          bit_idx_d    = '0;
          state_d      = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == IDX_LAST) begin
            state_d = S_PARITY;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_d[0];
      S_PARITY: serial_d = parity_q;
      default:  serial_d = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame in flight and restores req0 priority
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      serial_q     <= 1'b1;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      serial_q     <= serial_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule
